ex_stage: RTL and testbench
===========================

# ex_stage

Execute-stage datapath that consumes the decode/execute pipeline register outputs. It performs operand forwarding, ALU operations, and branch/jump resolution. It drives the PC-redirect signals back to fetch and the ALU result forward to the execute/memory register. An iterative 32-cycle shift-add multiplier (MUL, low word) is built in; while it runs, the block stalls the upstream pipeline.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ALUControlE  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 PASSB; 12-15 give result 0.
- ALUSrcAE  in  1  operand A select: 0 = forwarded rs1, 1 = PCE.
- ALUSrcBE  in  1  operand B select: 0 = forwarded rs2, 1 = immExtE.
- JumpE  in  1  unconditional jump.
- JalrE  in  1  jump target base is rs1 rather than PC.
- BranchE  in  1  conditional branch.
- funct3E  in  3  branch condition: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2 and 3 mean never taken.
- rs1_data_E, rs2_data_E  in  32  register file operands.
- PCE, immExtE  in  32  PC and extended immediate.
- ForwardAE, ForwardBE  in  2  operand source: 00 register, 01 ResultW, 10 ALUResultM, 11 register.
- ResultW, ALUResultM  in  32  forwarding sources.
- flush_e  in  1  current E instruction is squashed.
- ALUResultE  out  32  ALU or multiplier result.
- WriteDataE  out  32  forwarded rs2, used as store data.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  32  redirect target.
- stall_ex  out  1  hold D/E and earlier stages; bubble E/M.

## Operation
- Forwarded operands:
  - SrcA_fwd = mux(ForwardAE); SrcB_fwd = mux(ForwardBE).
  - SrcA = ALUSrcAE ? PCE : SrcA_fwd; SrcB = ALUSrcBE ? immExtE : SrcB_fwd.
- Shift amounts use SrcB[4:0]. SLT/SLTU produce a 0 or 1 result. All arithmetic wraps modulo 2^32.
- Branch compare always uses SrcA_fwd vs SrcB_fwd, independent of the ALUSrc selects.
- PCTargetE = (JalrE ? SrcA_fwd : PCE) + immExtE. When JalrE=1, bit 0 is cleared.
- PCSrcE = !flush_e & (JumpE | (BranchE & cond)).
- WriteDataE = SrcB_fwd.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: when ALUControlE==10 and !flush_e, latch SrcA and SrcB at the edge and go to BUSY with count=0. The operands are latched because forwarding sources move during the stall.
  - BUSY: each cycle, if multiplier[0] is set, add the multiplicand into the accumulator; then multiplicand <<= 1, multiplier >>= 1, count++. After the count==31 cycle, go to DONE.
  - DONE: ALUResultE = accumulator low 32 bits; go to IDLE unconditionally. The held MUL is not reissued.
- stall_ex = (IDLE & MUL in E & !flush_e) | BUSY. It is 0 in DONE.
- Upstream contract: the E inputs stay stable while stall_ex=1.
- flush_e asserted during BUSY or DONE aborts the operation: state returns to IDLE at the next edge, stall_ex drops combinationally in BUSY, and the accumulator is discarded.

## Timing
- Non-MUL operations: ALUResultE, PCSrcE and PCTargetE are combinational, in the same cycle, with zero latency.
- MUL first seen in E at cycle t:
  - stall_ex=1 in cycles t through t+32 (33 cycles).
  - DONE in cycle t+33, with the product on ALUResultE and stall_ex=0.
  - The next instruction enters E at t+34.
- During stall cycles, ALUResultE carries the combinational ALU value (don't-care downstream, because E/M is bubbled).
- Reset:
  - State: IDLE; count, operand latches and accumulator all 0.
  - Outputs: stall_ex=0. All other outputs are combinational from the inputs; ALUResultE follows the ALU.
- rst_n asserted mid-BUSY returns the FSM to IDLE immediately.

## Configuration
- RV_MUL_EN defined: the multiplier FSM is present and behaves as above.
- RV_MUL_EN undefined: no FSM state; ALUControlE==10 gives result 0; stall_ex is tied to 0.

## Structure
- A shared package holds:
  - the ALU opcode enum (alu_op_e, 4-bit);
  - the forward-select enum;
  - the branch funct3 constants;
  - the multiplier state enum (mul_state_e).
- One sub-module, ex_mul_iter, contains the multiplier FSM and datapath. Its interface is start, abort, a, b, busy, done, result.

## Test plan
- ADD: rs1=5, rs2=7, forward 00 -> ALUResultE=12, stall_ex=0.
- Forwarding: ForwardAE=10, ALUResultM=0x100, SUB with imm=1 -> 0xFF.
- BEQ: funct3=0, operands 3 and 3, PCE=0x40, imm=8 -> PCSrcE=1, PCTargetE=0x48.
  - Same case with flush_e=1 -> PCSrcE=0.
- JALR: rs1=0x1001, imm=4 -> PCTargetE=0x1004.
- MUL: 0xFFFFFFFF x 3, with ForwardAE changing mid-stall:
  - stall_ex high for exactly 33 cycles;
  - cycle t+33: ALUResultE=0xFFFFFFFD, stall_ex=0.
- MUL with flush_e pulsed at t+10 -> stall_ex=0 from t+10, FSM IDLE at t+11.
  - A following ADD then completes with zero added latency.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared types and helpers for the execute stage
package ex_stage_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_MUL   = 4'd10,
      ALU_PASSB = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG     = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10,
      FWD_REG_ALT = 2'b11
   } fwd_sel_e;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [XLEN-1:0] regv,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
      case (fwd_sel_e'(sel))
         FWD_WB:  fwd_mux = wb;
         FWD_MEM: fwd_mux = mem;
         default: fwd_mux = regv;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
      case (f3)
         F3_BEQ:  branch_taken = (a == b);
         F3_BNE:  branch_taken = (a != b);
         F3_BLT:  branch_taken = ($signed(a) < $signed(b));
         F3_BGE:  branch_taken = ($signed(a) >= $signed(b));
         F3_BLTU: branch_taken = (a < b);
         F3_BGEU: branch_taken = (a >= b);
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative 32-cycle shift-add multiplier (low word)
module ex_mul_iter import ex_stage_pkg::*; (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   mul_state_e      state, state_nxt;
   logic [4:0]      count;
   logic [XLEN-1:0] mcand, mplier, acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MUL_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MUL_IDLE: if (start) state_nxt = MUL_BUSY;
         MUL_BUSY: begin
            if (abort)               state_nxt = MUL_IDLE;
            else if (count == 5'd31) state_nxt = MUL_DONE;
         end
         default:  state_nxt = MUL_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == MUL_BUSY);
      done   = (state == MUL_DONE);
      result = acc;
   end

   // Operands are captured at start since forwarding sources move during the stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (state == MUL_IDLE && start) begin
         count  <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (state == MUL_BUSY && !abort) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 5'd1;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, branch resolution, optional multiplier
// Define RV_MUL_EN to build in the iterative MUL unit and its pipeline stall.
module ex_stage import ex_stage_pkg::*; (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      ALUControlE,
   input  logic            ALUSrcAE,
   input  logic            ALUSrcBE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            BranchE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] rs1_data_E,
   input  logic [XLEN-1:0] rs2_data_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] immExtE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic            flush_e,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            stall_ex
);

   alu_op_e         op;
   logic [XLEN-1:0] src_a_fwd, src_b_fwd, src_a, src_b, alu_result, target_base;
   logic [4:0]      shamt;

   assign op        = alu_op_e'(ALUControlE);
   assign src_a_fwd = fwd_mux(ForwardAE, rs1_data_E, ResultW, ALUResultM);
   assign src_b_fwd = fwd_mux(ForwardBE, rs2_data_E, ResultW, ALUResultM);
   assign src_a     = ALUSrcAE ? PCE : src_a_fwd;
   assign src_b     = ALUSrcBE ? immExtE : src_b_fwd;
   assign shamt     = src_b[4:0];

   always_comb begin
      alu_result = '0;
      case (op)
         ALU_ADD:   alu_result = src_a + src_b;
         ALU_SUB:   alu_result = src_a - src_b;
         ALU_AND:   alu_result = src_a & src_b;
         ALU_OR:    alu_result = src_a | src_b;
         ALU_XOR:   alu_result = src_a ^ src_b;
         ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
         ALU_SLL:   alu_result = src_a << shamt;
         ALU_SRL:   alu_result = src_a >> shamt;
         ALU_SRA:   alu_result = $unsigned($signed(src_a) >>> shamt);
         ALU_PASSB: alu_result = src_b;
         default:   alu_result = '0;
      endcase
   end

   // Branch compare deliberately ignores the ALUSrc selects.
   assign target_base = JalrE ? src_a_fwd : PCE;
   assign PCTargetE   = (target_base + immExtE) & ~{{(XLEN-1){1'b0}}, JalrE};
   assign PCSrcE      = !flush_e & (JumpE | (BranchE & branch_taken(funct3E, src_a_fwd, src_b_fwd)));
   assign WriteDataE  = src_b_fwd;

`ifdef RV_MUL_EN
   logic            mul_start, mul_busy, mul_done;
   logic [XLEN-1:0] mul_result;

   assign mul_start = (op == ALU_MUL) && !flush_e;

   ex_mul_iter u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mul_start),
      .abort  (flush_e),
      .a      (src_a),
      .b      (src_b),
      .busy   (mul_busy),
      .done   (mul_done),
      .result (mul_result)
   );

   assign stall_ex   = (mul_start & !mul_busy & !mul_done) | (mul_busy & !flush_e);
   assign ALUResultE = mul_done ? mul_result : alu_result;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
   assign stall_ex       = 1'b0;
   assign ALUResultE     = alu_result;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

   logic        clk, rst_n;
   logic [3:0]  ALUControlE;
   logic        ALUSrcAE, ALUSrcBE, JumpE, JalrE, BranchE, flush_e;
   logic [2:0]  funct3E;
   logic [31:0] rs1_data_E, rs2_data_E, PCE, immExtE, ResultW, ALUResultM;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultE, WriteDataE, PCTargetE;
   logic        PCSrcE, stall_ex;

   int errors = 0;
   int checks = 0;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
      .ALUSrcBE(ALUSrcBE), .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
      .funct3E(funct3E), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
      .PCE(PCE), .immExtE(immExtE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .ALUResultM(ALUResultM), .flush_e(flush_e),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE), .stall_ex(stall_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      ALUControlE = 4'd0; ALUSrcAE = 0; ALUSrcBE = 0; JumpE = 0; JalrE = 0; BranchE = 0;
      flush_e = 0; funct3E = 3'd0; rs1_data_E = 0; rs2_data_E = 0; PCE = 0; immExtE = 0;
      ResultW = 0; ALUResultM = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      clear_inputs();
      ALUControlE = op; rs1_data_E = a; rs2_data_E = b;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  t_op [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd15};
   logic [31:0] t_a  [13] = '{32'd5, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd5, 32'd5};
   logic [31:0] t_b  [13] = '{32'd7, 32'd5, 32'hFF00, 32'h0F0F, 32'h0F0F, 32'd1, 32'd1,
                              32'h21, 32'd4, 32'd4, 32'h1234, 32'd7, 32'd7};
   logic [31:0] t_e  [13] = '{32'd12, 32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0F0, 32'd1, 32'd0,
                              32'd2, 32'h08000000, 32'hF8000000, 32'h1234, 32'd0, 32'd0};

   initial begin
      int n;
      clear_inputs();
      rst_n = 1'b0;
      set_op(4'd0, 32'd5, 32'd7);
      #12;
      check("reset_stall", {31'd0, stall_ex}, 32'd0);
      check("reset_add", ALUResultE, 32'd12);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < 13; i++) begin
         set_op(t_op[i], t_a[i], t_b[i]);
         #1;
         check($sformatf("alu_op%0d", t_op[i]), ALUResultE, t_e[i]);
      end
      check("add_no_stall", {31'd0, stall_ex}, 32'd0);

      set_op(4'd1, 32'h55, 32'h0);
      ForwardAE = 2'b10; ALUResultM = 32'h100; ALUSrcBE = 1; immExtE = 32'd1;
      ForwardBE = 2'b01; ResultW = 32'hABC;
      #1;
      check("fwd_mem_sub", ALUResultE, 32'hFF);
      check("fwd_wb_store", WriteDataE, 32'hABC);
      ForwardBE = 2'b11; rs2_data_E = 32'h77;
      #1;
      check("fwd_11_reg", WriteDataE, 32'h77);

      set_op(4'd0, 32'd3, 32'd3);
      BranchE = 1; funct3E = 3'd0; PCE = 32'h40; immExtE = 32'd8; ALUSrcAE = 1;
      #1;
      check("beq_taken", {31'd0, PCSrcE}, 32'd1);
      check("beq_target", PCTargetE, 32'h48);
      flush_e = 1;
      #1;
      check("beq_flushed", {31'd0, PCSrcE}, 32'd0);
      flush_e = 0; funct3E = 3'd1;
      #1;
      check("bne_not", {31'd0, PCSrcE}, 32'd0);
      rs1_data_E = 32'hFFFFFFFF; rs2_data_E = 32'd1; funct3E = 3'd4;
      #1;
      check("blt_taken", {31'd0, PCSrcE}, 32'd1);
      funct3E = 3'd6;
      #1;
      check("bltu_not", {31'd0, PCSrcE}, 32'd0);
      funct3E = 3'd7;
      #1;
      check("bgeu_taken", {31'd0, PCSrcE}, 32'd1);
      funct3E = 3'd2;
      #1;
      check("f3_2_never", {31'd0, PCSrcE}, 32'd0);

      set_op(4'd0, 32'h1001, 32'd0);
      JumpE = 1; JalrE = 1; immExtE = 32'd4; PCE = 32'h200;
      #1;
      check("jalr_target", PCTargetE, 32'h1004);
      check("jalr_redirect", {31'd0, PCSrcE}, 32'd1);
      JalrE = 0; PCE = 32'h100; immExtE = 32'h20;
      #1;
      check("jal_target", PCTargetE, 32'h120);

`ifdef RV_MUL_EN
      next_cycle();
      set_op(4'd10, 32'hFFFFFFFF, 32'd3);
      #1;
      check("mul_stall_t", {31'd0, stall_ex}, 32'd1);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         if (!stall_ex) break;
         n++;
         if (n == 10) begin
            ForwardAE = 2'b01; ResultW = 32'h7;
         end
      end
      check("mul_stall_len", n, 33);
      check("mul_product", ALUResultE, 32'hFFFFFFFD);
      check("mul_done_stall", {31'd0, stall_ex}, 32'd0);
      next_cycle();
      set_op(4'd0, 32'd5, 32'd7);
      #1;
      check("post_mul_add", ALUResultE, 32'd12);
      check("post_mul_stall", {31'd0, stall_ex}, 32'd0);

      next_cycle();
      set_op(4'd10, 32'd6, 32'd7);
      repeat (10) next_cycle();
      check("mul_busy_t10", {31'd0, stall_ex}, 32'd1);
      flush_e = 1;
      #1;
      check("flush_drop", {31'd0, stall_ex}, 32'd0);
      next_cycle();
      set_op(4'd0, 32'd5, 32'd7);
      #1;
      check("flush_add", ALUResultE, 32'd12);
      check("flush_idle", {31'd0, stall_ex}, 32'd0);
      next_cycle();
      check("flush_idle2", {31'd0, stall_ex}, 32'd0);

      set_op(4'd10, 32'd2, 32'd2);
      repeat (5) next_cycle();
      rst_n = 1'b0;
      #1;
      set_op(4'd0, 32'd1, 32'd1);
      #1;
      check("rst_mid_busy", {31'd0, stall_ex}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      check("rst_after", {31'd0, stall_ex}, 32'd0);
`else
      next_cycle();
      set_op(4'd10, 32'hFFFFFFFF, 32'd3);
      #1;
      check("mul_off_result", ALUResultE, 32'd0);
      check("mul_off_stall", {31'd0, stall_ex}, 32'd0);
      repeat (3) next_cycle();
      check("mul_off_stall2", {31'd0, stall_ex}, 32'd0);
      n = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
